// File: rtl/keyboard_pkg.sv
// Shared scan-code constants and decoder state type for the PS/2 keyboard controller.
// Pure declarations: no logic, no latency, no flow control.
package keyboard_pkg;

   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_SPACE = 8'h29;
   localparam logic [7:0] SC_RIGHT = 8'h74;
   localparam logic [7:0] SC_LEFT  = 8'h6B;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BRK     = 2'd1,
      EXT     = 2'd2,
      EXT_BRK = 2'd3
   } dec_state_t;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: sync, glitch filter, 11-bit framing, odd parity, timeout.
// rx_valid/rx_err pulse one cycle after the filtered 11th falling edge; no backpressure (host must accept).
module ps2_rx #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 65_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_err
);

   localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

   logic          clk_s1, clk_s2, dat_s1, dat_s2;
   logic          clk_filt;
   logic [FW-1:0] filt_cnt;
   logic          fall;
   logic [9:0]    shift;
   logic [3:0]    bit_cnt;
   logic [TW-1:0] to_cnt;
   logic          frame_ok;
   logic          timeout;

   // Pins idle high, so syncs reset high to avoid a false edge after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
      end else begin
         clk_s1 <= ps2_clk;
         clk_s2 <= clk_s1;
         dat_s1 <= ps2_data;
         dat_s2 <= dat_s1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_filt <= 1'b1;
         filt_cnt <= '0;
      end else if (clk_s2 == clk_filt) begin
         filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
         clk_filt <= clk_s2;
         filt_cnt <= '0;
      end else begin
         filt_cnt <= filt_cnt + 1'b1;
      end
   end

   assign fall = clk_filt & ~clk_s2 & (filt_cnt == FILT_LAST);

   // After ten shifts: start in [0], d0..d7 in [8:1], parity in [9]; the stop bit is live on dat_s2.
   assign frame_ok = ~shift[0] & dat_s2 & (^shift[9:1]);
   assign timeout  = (bit_cnt != 4'd0) & (to_cnt == TO_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift    <= '0;
         bit_cnt  <= '0;
         to_cnt   <= '0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         rx_err   <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         rx_err   <= 1'b0;
         if (fall) begin
            to_cnt <= '0;
            if (bit_cnt == 4'd10) begin
               bit_cnt <= '0;
               if (frame_ok) begin
                  rx_valid <= 1'b1;
                  rx_data  <= shift[8:1];
               end else begin
                  rx_err <= 1'b1;
               end
            end else begin
               bit_cnt <= bit_cnt + 4'd1;
               shift   <= {dat_s2, shift[9:1]};
            end
         end else if (timeout) begin
            rx_err  <= 1'b1;
            bit_cnt <= '0;
            to_cnt  <= '0;
         end else if (bit_cnt != 4'd0) begin
            to_cnt <= to_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/keyboard_ctl.sv
// PS/2 keyboard to held-key levels for Space / Right / Left; key outputs update the cycle after a byte.
// No backpressure: the PS/2 device cannot be stalled, every received byte is consumed immediately.
import keyboard_pkg::*;

module keyboard_ctl #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 65_000
) (
   input  logic clk,
   input  logic rst,
   input  logic ps2_clk,
   input  logic ps2_data,
   output logic key_space,
   output logic key_right,
   output logic key_left,
   output logic frame_err
);

   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_err;
   dec_state_t state, state_nx;
   logic       space_nx, right_nx, left_nx;

   ps2_rx #(
      .FILTER_LEN     (FILTER_LEN),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_rx (
      .clk      (clk),
      .rst      (rst),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_err   (rx_err)
   );

   assign frame_err = rx_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         key_space <= 1'b0;
         key_right <= 1'b0;
         key_left  <= 1'b0;
      end else begin
         state     <= state_nx;
         key_space <= space_nx;
         key_right <= right_nx;
         key_left  <= left_nx;
      end
   end

   // A bad frame may have swallowed a prefix byte, so any partial sequence is abandoned.
   always_comb begin
      state_nx = state;
      space_nx = key_space;
      right_nx = key_right;
      left_nx  = key_left;
      if (rx_err) begin
         state_nx = IDLE;
      end else if (rx_valid) begin
         case (state)
            IDLE: begin
               if (rx_data == SC_EXT)
                  state_nx = EXT;
               else if (rx_data == SC_BREAK)
                  state_nx = BRK;
               else if (rx_data == SC_SPACE)
                  space_nx = 1'b1;
            end
            BRK: begin
               state_nx = IDLE;
               if (rx_data == SC_SPACE)
                  space_nx = 1'b0;
            end
            EXT: begin
               if (rx_data == SC_BREAK) begin
                  state_nx = EXT_BRK;
               end else if (rx_data != SC_EXT) begin
                  state_nx = IDLE;
                  if (rx_data == SC_RIGHT)
                     right_nx = 1'b1;
                  else if (rx_data == SC_LEFT)
                     left_nx = 1'b1;
               end
            end
            EXT_BRK: begin
               state_nx = IDLE;
               if (rx_data == SC_RIGHT)
                  right_nx = 1'b0;
               else if (rx_data == SC_LEFT)
                  left_nx = 1'b0;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

endmodule
